// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage issue/capture wrapper around a 64-bit combinational ALU
// Two-stage pipeline: S1 drives the ALU, S2 captures result plus branch decision.
module alu_issue #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b30,
    input  logic            in_alusrc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_is_branch,
    output logic            out_taken,
    output logic            out_illegal
);

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_PASS = 4'b1111;

    logic            s1_valid;
    logic [XLEN-1:0] s1_op1;
    logic [XLEN-1:0] s1_op2;
    logic [3:0]      s1_sel;
    logic [RD_W-1:0] s1_rd;
    logic            s1_is_branch;
    logic            s1_illegal;
    logic [2:0]      s1_funct3;
    logic            s2_valid;

    logic            s2_free;
    logic            in_fire;
    logic [3:0]      dec_sel;
    logic            dec_is_branch;
    logic            dec_illegal;
    logic            taken;

    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        dec_sel       = SEL_PASS;
        dec_is_branch = 1'b0;
        dec_illegal   = 1'b0;
        case (in_aluop)
            2'b00: dec_sel = SEL_ADD;
            2'b01: begin
                dec_sel       = SEL_SUB;
                dec_is_branch = 1'b1;
                dec_illegal   = (in_funct3 != 3'b000) && (in_funct3 != 3'b001);
            end
            2'b10: begin
                case (in_funct3)
                    // Bit 30 only selects SUB for register-register forms; ADDI ignores it.
                    3'b000:  dec_sel = (in_funct7b30 && !in_alusrc) ? SEL_SUB : SEL_ADD;
                    3'b111:  dec_sel = SEL_AND;
                    3'b110:  dec_sel = SEL_OR;
                    default: begin
                        dec_sel     = SEL_PASS;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_sel = SEL_PASS;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        if (s1_is_branch) begin
            if (s1_funct3 == 3'b000)
                taken = alu_zero;
            else if (s1_funct3 == 3'b001)
                taken = !alu_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_op1       <= '0;
            s1_op2       <= '0;
            s1_sel       <= 4'b0000;
            s1_rd        <= '0;
            s1_is_branch <= 1'b0;
            s1_illegal   <= 1'b0;
            s1_funct3    <= 3'b000;
        end else if (in_fire) begin
            s1_valid     <= 1'b1;
            s1_op1       <= in_rs1;
            s1_op2       <= in_alusrc ? in_imm : in_rs2;
            s1_sel       <= dec_sel;
            s1_rd        <= in_rd;
            s1_is_branch <= dec_is_branch;
            s1_illegal   <= dec_illegal;
            s1_funct3    <= in_funct3;
        end else if (s2_free) begin
            s1_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_is_branch <= 1'b0;
            out_taken     <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= alu_result;
                out_rd        <= s1_rd;
                out_is_branch <= s1_is_branch;
                out_taken     <= taken;
                out_illegal   <= s1_illegal;
            end
        end
    end

    assign alu_op1   = s1_op1;
    assign alu_op2   = s1_op2;
    assign alu_sel   = s1_sel;
    assign out_valid = s2_valid;

endmodule
